// File: rtl/frame_axis_pkg.sv
// rtl/frame_axis_pkg.sv - shared types, sizing constants and tkeep helper for the frame packer
package frame_axis_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam int DATA_SIZE_DEF   = 4;
  localparam int TDATA_WIDTH_DEF = 32;
  localparam int SPW    = TDATA_WIDTH_DEF / DATA_SIZE_DEF;
  localparam int KEEP_W = TDATA_WIDTH_DEF / 8;

  // Byte-enable mask covering nsamples samples of data_size bits, LSB first.
  function automatic logic [63:0] keep_from_count(input int unsigned nsamples,
                                                   input int unsigned data_size);
    int unsigned nbytes;
    nbytes = (nsamples * data_size + 7) / 8;
    if (nbytes >= 64) return '1;
    return (64'd1 << nbytes) - 64'd1;
  endfunction

endpackage

// File: rtl/frame_axis_fifo.sv
// rtl/frame_axis_fifo.sv - first-word-fall-through FIFO with full/empty and simultaneous push/pop
module frame_axis_fifo #(
  parameter int WIDTH = 37,
  parameter int ADD   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << ADD;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADD:0]     wr_ptr;
  logic [ADD:0]     rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr == {~rd_ptr[ADD], rd_ptr[ADD-1:0]});
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[ADD-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADD-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/frame_axis_packer.sv
// rtl/frame_axis_packer.sv - packs narrow frame samples into AXI4-Stream words with backpressure and drop accounting
module frame_axis_packer
  import frame_axis_pkg::*;
#(
  parameter int DATA_SIZE   = TDATA_WIDTH_DEF / SPW,
  parameter int TDATA_WIDTH = 8 * KEEP_W,
  parameter int LENGTH_SIZE = 6,
  parameter int FIFO_ADD    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LENGTH_SIZE:0]     frame_len,
  input  logic                     in_valid,
  input  logic [DATA_SIZE-1:0]     in_data,
  output logic                     busy,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     frame_done,
  input  logic                     clear,
  output logic [15:0]              drop_cnt,
  output logic                     overrun
);

  localparam int LANES  = TDATA_WIDTH / DATA_SIZE;
  localparam int KBYTES = TDATA_WIDTH / 8;
  localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int FW     = TDATA_WIDTH + KBYTES + 1;
  localparam logic [LENGTH_SIZE:0] MAX_LEN = {1'b1, {LENGTH_SIZE{1'b0}}};

  state_t state, state_next;

  logic [LENGTH_SIZE:0]   len;
  logic [LENGTH_SIZE:0]   cnt;
  logic [LENGTH_SIZE:0]   cnt_next;
  logic [IDX_W-1:0]       idx;
  logic [TDATA_WIDTH-1:0] shift_word;
  logic [TDATA_WIDTH-1:0] word_next;
  logic                   pend_valid;
  logic [TDATA_WIDTH-1:0] pend_data;
  logic [KBYTES-1:0]      pend_keep;
  logic                   pend_last;
  logic                   len_ok;
  logic                   accept;
  logic                   last_sample;
  logic                   word_end;
  logic                   pop;
  logic                   drop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FW-1:0]          fifo_dout;

  assign len_ok      = (frame_len != '0) && (frame_len <= MAX_LEN);
  assign accept      = (state == RUN) && in_valid;
  assign cnt_next    = cnt + {{LENGTH_SIZE{1'b0}}, 1'b1};
  assign last_sample = (cnt_next == len);
  assign word_end    = (idx == IDX_W'(LANES - 1)) || last_sample;
  assign word_next   = shift_word | (TDATA_WIDTH'(in_data) << (idx * DATA_SIZE));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && len_ok) state_next = RUN;
      RUN:     if (accept && last_sample) state_next = FLUSH;
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len        <= '0;
      cnt        <= '0;
      idx        <= '0;
      shift_word <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_keep  <= '0;
      pend_last  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == FLUSH);
      pend_valid <= 1'b0;
      if (state == IDLE && start && len_ok) begin
        len        <= frame_len;
        cnt        <= '0;
        idx        <= '0;
        shift_word <= '0;
      end
      if (accept) begin
        cnt <= cnt_next;
        if (word_end) begin
          // Word leaves through the pending register next cycle; lanes restart empty.
          shift_word <= '0;
          idx        <= '0;
          pend_valid <= 1'b1;
          pend_data  <= word_next;
          pend_keep  <= KBYTES'(keep_from_count(32'(idx) + 32'd1, DATA_SIZE));
          pend_last  <= last_sample;
        end else begin
          shift_word <= word_next;
          idx        <= idx + IDX_W'(1);
        end
      end
    end
  end

  assign pop  = m_axis_tvalid && m_axis_tready;
  assign drop = pend_valid && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      overrun  <= 1'b0;
    end else if (clear) begin
      drop_cnt <= drop ? 16'd1 : 16'd0;
      overrun  <= drop;
    end else if (drop) begin
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      overrun <= 1'b1;
    end
  end

  frame_axis_fifo #(
    .WIDTH (FW),
    .ADD   (FIFO_ADD)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pend_valid),
    .din   ({pend_last, pend_keep, pend_data}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = fifo_dout;
  assign m_axis_tvalid = !fifo_empty;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_frame_axis_packer.sv
// tb/tb_frame_axis_packer.sv - directed self-checking bench for frame_axis_packer
module tb_frame_axis_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  frame_len = '0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_data = '0;
  logic        busy;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        frame_done;
  logic        clear = 1'b0;
  logic [15:0] drop_cnt;
  logic        overrun;

  logic tready_set = 1'b1;
  logic toggle_en  = 1'b0;
  logic tog        = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  logic [36:0] got[$];
  logic [36:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [36:0] prev_word;

  assign m_axis_tready = toggle_en ? tog : tready_set;

  frame_axis_packer #(
    .DATA_SIZE   (4),
    .TDATA_WIDTH (32),
    .LENGTH_SIZE (6),
    .FIFO_ADD    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .frame_len     (frame_len),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .busy          (busy),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .frame_done    (frame_done),
    .clear         (clear),
    .drop_cnt      (drop_cnt),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    tog = ~tog;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
        check("stall_word", {27'd0, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, {27'd0, prev_word});
      end
      if (m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
      if (frame_done) done_cnt++;
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_word  = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_add(input int len, input int base);
    for (int w = 0; w * 8 < len; w++) begin
      logic [31:0] d;
      logic [3:0]  k;
      int n;
      d = '0;
      n = (len - w * 8 < 8) ? len - w * 8 : 8;
      for (int j = 0; j < n; j++) d = d | (32'((base + w * 8 + j) & 15) << (4 * j));
      k = 4'((1 << ((n * 4 + 7) / 8)) - 1);
      exp_q.push_back({(w * 8 + n == len), k, d});
    end
  endtask

  task automatic run_frame(input int len, input int base);
    start = 1'b1;
    frame_len = 7'(len);
    tick();
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    for (int k = 0; k < len; k++) begin
      in_valid = 1'b1;
      in_data  = 4'((base + k) & 15);
      tick();
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic wait_words(input int n, input int budget);
    int c;
    c = 0;
    while (got.size() < n && c < budget) begin
      tick();
      c++;
    end
    check("wait_words", {63'd0, got.size() >= n}, 64'd1);
    repeat (4) tick();
  endtask

  task automatic compare(input string tag);
    int m;
    check({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s_word%0d", tag, i), {27'd0, got[i]}, {27'd0, exp_q[i]});
    got.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_tvalid"}, {63'd0, m_axis_tvalid}, 64'd0);
    check({tag, "_tdata"}, {32'd0, m_axis_tdata}, 64'd0);
    check({tag, "_tkeep"}, {60'd0, m_axis_tkeep}, 64'd0);
    check({tag, "_tlast"}, {63'd0, m_axis_tlast}, 64'd0);
    check({tag, "_frame_done"}, {63'd0, frame_done}, 64'd0);
    check({tag, "_drop_cnt"}, {48'd0, drop_cnt}, 64'd0);
    check({tag, "_overrun"}, {63'd0, overrun}, 64'd0);
  endtask

  initial begin
    int d0;

    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // Full 64-sample frame, continuous input, no backpressure
    d0 = done_cnt;
    model_add(64, 3);
    run_frame(64, 3);
    wait_words(8, 50);
    compare("full64");
    check("full64_done", 64'(done_cnt - d0), 64'd1);
    check("full64_drop", {48'd0, drop_cnt}, 64'd0);

    // 13-sample frame with hand-computed words and latency checks
    start = 1'b1;
    frame_len = 7'd13;
    tick();
    start = 1'b0;
    for (int k = 0; k < 13; k++) begin
      in_valid = 1'b1;
      in_data  = 4'(k + 1);
      tick();
      if (k == 7) check("w0_not_yet", {63'd0, m_axis_tvalid}, 64'd0);
      if (k == 8) begin
        check("w0_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
        check("w0_tdata", {32'd0, m_axis_tdata}, 64'h87654321);
        check("w0_tkeep", {60'd0, m_axis_tkeep}, 64'hF);
        check("w0_tlast", {63'd0, m_axis_tlast}, 64'd0);
      end
    end
    in_valid = 1'b0;
    check("len13_m1_done", {63'd0, frame_done}, 64'd0);
    check("len13_m1_busy", {63'd0, busy}, 64'd1);
    tick();
    check("len13_m2_done", {63'd0, frame_done}, 64'd1);
    check("len13_m2_busy", {63'd0, busy}, 64'd0);
    check("w1_tdata", {32'd0, m_axis_tdata}, 64'h000DCBA9);
    check("w1_tkeep", {60'd0, m_axis_tkeep}, 64'h7);
    check("w1_tlast", {63'd0, m_axis_tlast}, 64'd1);
    model_add(13, 1);
    wait_words(2, 20);
    compare("len13");

    // tready toggling every cycle
    toggle_en = 1'b1;
    model_add(64, 7);
    run_frame(64, 7);
    wait_words(8, 100);
    toggle_en = 1'b0;
    compare("toggle");
    check("toggle_drop", {48'd0, drop_cnt}, 64'd0);

    // Three frames into a stalled sink: 16 buffered, 8 dropped
    tready_set = 1'b0;
    model_add(64, 0);
    run_frame(64, 0);
    model_add(64, 5);
    run_frame(64, 5);
    run_frame(64, 9);
    check("ovf_drop_cnt", {48'd0, drop_cnt}, 64'd8);
    check("ovf_overrun", {63'd0, overrun}, 64'd1);
    check("ovf_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    tready_set = 1'b1;
    wait_words(16, 60);
    compare("ovf");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_drop_cnt", {48'd0, drop_cnt}, 64'd0);
    check("clear_overrun", {63'd0, overrun}, 64'd0);

    // Ignored starts: zero length, out of range, and mid-frame
    start = 1'b1;
    frame_len = 7'd0;
    tick();
    check("len0_ignored", {63'd0, busy}, 64'd0);
    frame_len = 7'd65;
    tick();
    start = 1'b0;
    check("len65_ignored", {63'd0, busy}, 64'd0);
    d0 = done_cnt;
    start = 1'b1;
    frame_len = 7'd16;
    tick();
    for (int k = 0; k < 16; k++) begin
      in_valid  = 1'b1;
      in_data   = 4'((2 + k) & 15);
      start     = (k == 4);
      frame_len = (k == 4) ? 7'd7 : 7'd16;
      tick();
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("midstart_m1_busy", {63'd0, busy}, 64'd1);
    tick();
    check("midstart_m2_done", {63'd0, frame_done}, 64'd1);
    model_add(16, 2);
    wait_words(2, 20);
    compare("midstart");
    check("midstart_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Reset mid-frame with words buffered
    tready_set = 1'b0;
    d0 = done_cnt;
    start = 1'b1;
    frame_len = 7'd64;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = 4'(k & 15);
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    rst = 1'b1;
    tick();
    check_reset_values("midrst");
    rst = 1'b0;
    tready_set = 1'b1;
    got.delete();
    exp_q.delete();
    model_add(8, 4);
    run_frame(8, 4);
    wait_words(1, 20);
    compare("after_rst");
    check("after_rst_done_cnt", 64'(done_cnt - d0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
